// File: rtl/uart_pkg.sv
// Shared types, register offsets and STATUS bit positions for the MMIO UART transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_MSB = 15;

   function automatic logic [31:0] pack_status(input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       ovf,
                                               input logic [7:0] count);
      logic [31:0] s;
      s                            = 32'h0000_0000;
      s[ST_BUSY]                   = busy;
      s[ST_FULL]                   = full;
      s[ST_EMPTY]                  = empty;
      s[ST_OVF]                    = ovf;
      s[ST_COUNT_MSB:ST_COUNT_LSB] = count;
      return s;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART: core store path plus load address/data.
interface mmio_uart_tx_if;
   logic        mem_write_en;
   logic [31:0] write_address;
   logic [31:0] write_data;
   logic [31:0] read_address;
   logic [31:0] read_data;

   modport master (
      output mem_write_en, write_address, write_data, read_address,
      input  read_data
   );

   modport slave (
      input  mem_write_en, write_address, write_data, read_address,
      output read_data
   );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head output; depth must be a power of two.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   // Guard handshakes and compute next pointers/occupancy.
   always_comb begin
      pop_ok_s  = pop && (count_q != {CW{1'b0}});
      push_ok_s = push && ((count_q != CW'(DEPTH)) || pop_ok_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == {CW{1'b0}});
   assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO, STATUS is polled via the load path.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 104,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
   input  logic           clk,
   input  logic           rst_n,
   mmio_uart_tx_if.slave  bus,
   output logic           tx
);
   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [31:0]    TX_ADDR   = BASE_ADDR + TXDATA_OFS;
   localparam logic [31:0]    ST_ADDR   = BASE_ADDR + STATUS_OFS;

   uart_state_t   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   read_data_q, read_data_d;

   logic          sel_tx_s, sel_st_s, ovf_event_s;
   logic          fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   logic [7:0]    fifo_dout_s;
   logic [CW-1:0] fifo_count_s;
   logic [31:0]   status_s;

   uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push_s),
      .din   (bus.write_data[7:0]),
      .pop   (fifo_pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Address decode, overflow flag, STATUS assembly and load mux.
   always_comb begin
      sel_tx_s    = bus.mem_write_en && (bus.write_address == TX_ADDR);
      sel_st_s    = bus.mem_write_en && (bus.write_address == ST_ADDR);
      fifo_pop_s  = (state_q == IDLE) && !fifo_empty_s;
      fifo_push_s = sel_tx_s && (!fifo_full_s || fifo_pop_s);
      ovf_event_s = sel_tx_s && fifo_full_s && !fifo_pop_s;
      // A drop in the same cycle as a clear must leave the flag set.
      if (ovf_event_s) begin
         ovf_d = 1'b1;
      end else if (sel_st_s && bus.write_data[ST_OVF]) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      status_s = pack_status(state_q != IDLE, fifo_full_s, fifo_empty_s, ovf_q, 8'(fifo_count_s));
      if (bus.read_address == ST_ADDR) begin
         read_data_d = status_s;
      end else begin
         read_data_d = 32'h0000_0000;
      end
   end

   // Transmit sequencing: next state, baud/bit counters, shift register and line level.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         IDLE: begin
            if (fifo_pop_s) begin
               shift_d = fifo_dout_s;
               baud_d  = {BW{1'b0}};
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = {BW{1'b0}};
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = {BW{1'b0}};
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = {BW{1'b0}};
               state_d = IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = {BW{1'b0}};
         end
      endcase
      // Line level follows the state being entered so tx changes on the same edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         baud_q      <= {BW{1'b0}};
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         tx_q        <= 1'b1;
         ovf_q       <= 1'b0;
         read_data_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ovf_q       <= ovf_d;
         read_data_q <= read_data_d;
      end
   end

   assign bus.read_data = read_data_q;
   assign tx            = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; expected values are hand-derived.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h0000_2000;
   localparam logic [31:0] STAT = 32'h0000_2004;

   logic clk = 1'b0;
   logic rst_n;
   logic tx;
   int   vectors     = 0;
   int   miscompares = 0;

   mmio_uart_tx_if bus_if ();

   mmio_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
      bus_if.mem_write_en  = 1'b1;
      bus_if.write_address = addr;
      bus_if.write_data    = data;
   endtask

   task automatic idle_bus();
      bus_if.mem_write_en  = 1'b0;
      bus_if.write_address = 32'h0000_0000;
      bus_if.write_data    = 32'h0000_0000;
   endtask

   // Expected line level at cycle i (0..39) of a frame carrying b.
   function automatic logic exp_bit(input logic [7:0] b, input int i);
      if (i < 4)       return 1'b0;
      else if (i < 36) return b[(i - 4) / 4];
      else             return 1'b1;
   endfunction

   task automatic check_frame(input logic [7:0] b, input int first);
      for (int i = first; i < 40; i++) begin
         if (i != first) step();
         chk($sformatf("tx_%02h_c%0d", b, i), {31'b0, tx}, {31'b0, exp_bit(b, i)});
      end
   endtask

   task automatic gap_and_frame(input logic [7:0] b);
      step();
      chk($sformatf("gap_before_%02h", b), {31'b0, tx}, 32'd1);
      step();
      check_frame(b, 0);
   endtask

   task automatic tail(input string tag, input logic [31:0] stop_st, input logic [31:0] idle_st);
      step();
      chk({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
      chk({tag, "_stop_status"}, bus_if.read_data, stop_st);
      step();
      chk({tag, "_idle_status"}, bus_if.read_data, idle_st);
   endtask

   initial begin
      rst_n               = 1'b0;
      idle_bus();
      bus_if.read_address = STAT;

      // Reset
      repeat (3) step();
      chk("reset_tx", {31'b0, tx}, 32'd1);
      chk("reset_rd", bus_if.read_data, 32'h0);
      rst_n = 1'b1;
      step();
      chk("reset_status", bus_if.read_data, 32'h0000_0004);

      // Single byte
      drive_store(BASE, 32'h0000_00A5);
      step();
      idle_bus();
      step();
      check_frame(8'hA5, 0);
      tail("single", 32'h0000_0005, 32'h0000_0004);

      // Back-to-back stores
      drive_store(BASE, 32'h01);
      step();
      chk("b2b_st0", bus_if.read_data, 32'h0000_0004);
      drive_store(BASE, 32'h02);
      step();
      chk("b2b_st1", bus_if.read_data, 32'h0000_0100);
      chk("b2b_tx0", {31'b0, tx}, 32'd0);
      drive_store(BASE, 32'h03);
      step();
      chk("b2b_st2", bus_if.read_data, 32'h0000_0101);
      chk("b2b_tx1", {31'b0, tx}, 32'd0);
      idle_bus();
      step();
      chk("b2b_peak", bus_if.read_data, 32'h0000_0201);
      check_frame(8'h01, 2);
      gap_and_frame(8'h02);
      gap_and_frame(8'h03);
      tail("b2b", 32'h0000_0005, 32'h0000_0004);

      // Overflow: six stores, sixth dropped
      for (int i = 0; i < 6; i++) begin
         drive_store(BASE, 32'h10 + i);
         step();
      end
      idle_bus();
      step();
      chk("ovf_status", bus_if.read_data, 32'h0000_040B);
      check_frame(8'h10, 5);
      gap_and_frame(8'h11);
      gap_and_frame(8'h12);
      gap_and_frame(8'h13);
      gap_and_frame(8'h14);
      tail("ovf", 32'h0000_000D, 32'h0000_000C);
      drive_store(STAT, 32'h0000_0008);
      step();
      idle_bus();
      chk("ovf_pre_clear", bus_if.read_data, 32'h0000_000C);
      step();
      chk("ovf_cleared", bus_if.read_data, 32'h0000_0004);
      chk("ovf_no_sixth", {31'b0, tx}, 32'd1);

      // Full FIFO with a store on the pop cycle
      for (int i = 0; i < 5; i++) begin
         drive_store(BASE, 32'h20 + i);
         step();
      end
      idle_bus();
      check_frame(8'h20, 3);
      step();
      chk("fp_idle_tx", {31'b0, tx}, 32'd1);
      drive_store(BASE, 32'h25);
      step();
      idle_bus();
      chk("fp_start_tx", {31'b0, tx}, 32'd0);
      step();
      chk("fp_status", bus_if.read_data, 32'h0000_0403);
      check_frame(8'h21, 1);
      gap_and_frame(8'h22);
      gap_and_frame(8'h23);
      gap_and_frame(8'h24);
      gap_and_frame(8'h25);
      tail("fp", 32'h0000_0005, 32'h0000_0004);

      // Reset during DATA bit 3
      drive_store(BASE, 32'hC3);
      step();
      drive_store(BASE, 32'h99);
      step();
      idle_bus();
      repeat (17) step();
      chk("mid_bit3_tx", {31'b0, tx}, 32'd0);
      rst_n = 1'b0;
      step();
      chk("mid_reset_tx", {31'b0, tx}, 32'd1);
      chk("mid_reset_rd", bus_if.read_data, 32'h0);
      rst_n = 1'b1;
      step();
      chk("mid_reset_status", bus_if.read_data, 32'h0000_0004);
      drive_store(BASE, 32'h3C);
      step();
      idle_bus();
      step();
      check_frame(8'h3C, 0);
      tail("post_reset", 32'h0000_0005, 32'h0000_0004);

      // Address miss and non-STATUS reads
      drive_store(BASE + 32'd8, 32'h77);
      step();
      idle_bus();
      step();
      chk("miss_status", bus_if.read_data, 32'h0000_0004);
      chk("miss_tx", {31'b0, tx}, 32'd1);
      step();
      chk("miss_status2", bus_if.read_data, 32'h0000_0004);
      chk("miss_tx2", {31'b0, tx}, 32'd1);
      bus_if.write_address = BASE;
      bus_if.write_data    = 32'h55;
      step();
      step();
      chk("no_strobe_status", bus_if.read_data, 32'h0000_0004);
      idle_bus();
      bus_if.read_address = BASE;
      step();
      chk("read_txdata", bus_if.read_data, 32'h0);
      bus_if.read_address = 32'h0000_1234;
      step();
      chk("read_other", bus_if.read_data, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
